// File: rtl/input_feed_scheduler.sv
// Row-buffer load/feed sequencer for an N x N systolic array: accepts a tile stream, then issues skewed reads.
// Optional build macro TRANSPOSE_LOAD_EN selects a column-major load stream.
module input_feed_scheduler #(
    parameter int matrixSize = 4,
    parameter int dataSize   = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      inValid,
    input  logic [dataSize-1:0]                       inData,
    output logic                                      inReady,
    input  logic                                      feedStall,
    output logic [matrixSize-1:0]                     writeEnable,
    output logic [dataSize-1:0]                       writeElement,
    output logic [$clog2(matrixSize)-1:0]             writeLocation,
    output logic [matrixSize*$clog2(matrixSize)-1:0]  readLocation,
    output logic [matrixSize-1:0]                     rowValid,
    output logic                                      busy,
    output logic                                      done
);

    localparam int AW = $clog2(matrixSize);
    localparam int LW = $clog2(matrixSize * matrixSize);
    localparam int TW = $clog2(2 * matrixSize);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FEED  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [LW-1:0] LAST_K = LW'(matrixSize * matrixSize - 1);
    localparam logic [TW-1:0] LAST_T = TW'(2 * matrixSize - 2);

    logic [1:0]            state;
    logic [LW-1:0]         loadCount;
    logic [TW-1:0]         feedCount;
    logic                  accept;
    logic [AW-1:0]         rowSel;
    logic [AW-1:0]         colSel;
    logic [matrixSize-1:0] active;
    logic signed [TW+1:0]  skew;
    logic [matrixSize-1:0] vld_p1;

    assign inReady = (state == LOAD);
    assign accept  = inValid & inReady;
    assign busy    = (state != IDLE);
    assign done    = (state == DRAIN);

    // Element index k splits as {k/N, k%N}; N is a power of two so these are plain bit fields.
`ifdef TRANSPOSE_LOAD_EN
    assign rowSel = loadCount[AW-1:0];
    assign colSel = loadCount[LW-1:AW];
`else
    assign rowSel = loadCount[LW-1:AW];
    assign colSel = loadCount[AW-1:0];
`endif

    assign writeEnable   = accept ? (matrixSize'(1) << rowSel) : '0;
    assign writeElement  = accept ? inData : '0;
    assign writeLocation = accept ? colSel : '0;

    // Diagonal skew: row r sees column t-r while that difference lies inside the tile.
    always_comb begin
        active       = '0;
        readLocation = '0;
        skew         = '0;
        for (int r = 0; r < matrixSize; r++) begin
            skew = $signed({2'b00, feedCount}) - $signed((TW+2)'(r));
            if ((state == FEED) && (skew >= 0) && (skew < $signed((TW+2)'(matrixSize)))) begin
                active[r]                = 1'b1;
                readLocation[r*AW +: AW] = skew[AW-1:0];
            end
        end
    end

    // Stage p1: valid aligned with the row buffer's one-cycle synchronous read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= '0;
        end else begin
            vld_p1 <= active & {matrixSize{~feedStall}};
        end
    end

    assign rowValid = vld_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            loadCount <= '0;
            feedCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD;
                        loadCount <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (loadCount == LAST_K) begin
                            state     <= FEED;
                            feedCount <= '0;
                        end else begin
                            loadCount <= loadCount + LW'(1);
                        end
                    end
                end
                FEED: begin
                    // A stall holds t so the same addresses are re-issued next cycle.
                    if (!feedStall) begin
                        if (feedCount == LAST_T) begin
                            state <= DRAIN;
                        end else begin
                            feedCount <= feedCount + TW'(1);
                        end
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_feed_scheduler.sv
// Directed bench for input_feed_scheduler (N=4): load mapping, skewed feed, stalls, gaps, abort.
module tb_input_feed_scheduler;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            inValid;
    logic [DW-1:0]   inData;
    logic            inReady;
    logic            feedStall;
    logic [N-1:0]    writeEnable;
    logic [DW-1:0]   writeElement;
    logic [AW-1:0]   writeLocation;
    logic [N*AW-1:0] readLocation;
    logic [N-1:0]    rowValid;
    logic            busy;
    logic            done;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] mem [N][N];
    logic [3:0] rvTab [8];

    always #5 clk = ~clk;

    input_feed_scheduler #(.matrixSize(N), .dataSize(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .inValid(inValid), .inData(inData),
        .inReady(inReady), .feedStall(feedStall), .writeEnable(writeEnable),
        .writeElement(writeElement), .writeLocation(writeLocation),
        .readLocation(readLocation), .rowValid(rowValid), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] expReadLoc(input int t);
        logic [N*AW-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            if (t - r >= 0 && t - r < N) v[r*AW +: AW] = AW'(t - r);
        return v;
    endfunction

    function automatic logic [N-1:0] expActive(input int t);
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < N; r++)
            if (t - r >= 0 && t - r < N) v[r] = 1'b1;
        return v;
    endfunction

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, inReady, 0);
        check({tag, "_we"}, writeEnable, 0);
        check({tag, "_rv"}, rowValid, 0);
        check({tag, "_rl"}, readLocation, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of the FEED entry cycle.
    task automatic loadTile(input bit gaps, input bit strayStart, input int expCycles);
        int k, cyc, row, col, writes;
        k = 0; cyc = 0; writes = 0;
        for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) mem[r][c] = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ld_ready", inReady, 1);
        while (k < N*N && cyc < 64) begin
            start = (strayStart && k == 2) ? 1'b1 : 1'b0;
            if (gaps && cyc % 2 == 1) begin
                inValid = 1'b0;
                inData  = 16'hdead;
            end else begin
                inValid = 1'b1;
                inData  = DW'(k + 1);
            end
            #1;
`ifdef TRANSPOSE_LOAD_EN
            row = k % N; col = k / N;
`else
            row = k / N; col = k % N;
`endif
            if (inValid) begin
                check($sformatf("ld_we_k%0d", k), writeEnable, 32'(1 << row));
                check($sformatf("ld_loc_k%0d", k), writeLocation, col);
                check($sformatf("ld_dat_k%0d", k), writeElement, k + 1);
            end else begin
                check("ld_gap_we", writeEnable, 0);
            end
            for (int r = 0; r < N; r++)
                if (writeEnable[r]) begin
                    mem[r][writeLocation] = writeElement;
                    writes++;
                end
            @(posedge clk); #1;
            if (inValid) k++;
            cyc++;
        end
        inValid = 1'b0;
        start   = 1'b0;
        check("ld_cycles", cyc, expCycles);
        check("ld_writes", writes, N*N);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
`ifdef TRANSPOSE_LOAD_EN
                check($sformatf("ld_mem_r%0dc%0d", r, c), mem[r][c], c*N + r + 1);
`else
                check($sformatf("ld_mem_r%0dc%0d", r, c), mem[r][c], r*N + c + 1);
`endif
        check("feed_entry_busy", busy, 1);
        check("feed_entry_ready", inReady, 0);
    endtask

    // Feed phase with a per-cycle stall mask; abortAt >= 0 fires reset at that cycle.
    task automatic feedTile(input logic [15:0] stallMask, input int abortAt);
        int t, c, drain, finished;
        int cnt [N];
        logic [N-1:0]    expRv;
        logic [N*AW-1:0] prevRl;
        t = 0; drain = 0; finished = 0; expRv = '0; prevRl = '0;
        for (int r = 0; r < N; r++) cnt[r] = 0;
        for (c = 0; c < 40 && !finished; c++) begin
            feedStall = (c < 16) ? stallMask[c] : 1'b0;
            if (c == abortAt) begin
                rst = 1'b1;
                #1;
                checkIdleOutputs("abort");
                rst = 1'b0;
                feedStall = 1'b0;
                return;
            end
            #1;
            check($sformatf("fd_rv_c%0d", c), rowValid, expRv);
            if (stallMask == 16'h0 && c < 8)
                check($sformatf("fd_rvtab_c%0d", c), rowValid, rvTab[c]);
            check($sformatf("fd_rl_c%0d", c), readLocation, drain ? '0 : expReadLoc(t));
            check($sformatf("fd_done_c%0d", c), done, drain);
            for (int r = 0; r < N; r++)
                if (rowValid[r]) begin
                    check($sformatf("fd_col_r%0d", r), prevRl[r*AW +: AW], cnt[r]);
                    cnt[r]++;
                end
            prevRl = readLocation;
            if (drain) begin
                finished = 1;
                expRv = '0;
            end else begin
                expRv = expActive(t) & {N{~feedStall}};
                if (!feedStall) begin
                    if (t == 2*N - 2) drain = 1;
                    else t++;
                end
            end
            @(posedge clk); #1;
        end
        feedStall = 1'b0;
        check("fd_finished", finished, 1);
        for (int r = 0; r < N; r++) check($sformatf("fd_count_r%0d", r), cnt[r], N);
        check("post_busy", busy, 0);
        check("post_rv", rowValid, 0);
    endtask

    initial begin
        rvTab = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rst = 1'b1; start = 1'b0; inValid = 1'b0; inData = '0; feedStall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        loadTile(1'b0, 1'b0, 16);
        feedTile(16'h0000, -1);

        loadTile(1'b0, 1'b0, 16);
        feedTile(16'h0018, -1);

        loadTile(1'b1, 1'b0, 31);
        feedTile(16'h0000, -1);

        loadTile(1'b0, 1'b0, 16);
        feedTile(16'h0000, 2);
        @(posedge clk); #1;
        checkIdleOutputs("after_abort");

        loadTile(1'b0, 1'b1, 16);
        feedTile(16'h0000, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
